muldiv_seq: RTL and testbench

//   Multi-cycle sequencer for MULT/MULTU/DIV/DIVU that produces the HI/LO pair for the EX stage.
//   It takes the multiply/divide work off the single-cycle ALU path:
//     - multiply runs through a fixed-latency pipe;
//     - divide runs as a 32-iteration restoring loop.

---
 rtl/muldiv_seq.sv | 170 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that produces the HI/LO pair for EX.
// Multiply uses a fixed-latency pipe; divide is a 32-step restoring loop.
`timescale 1ns/1ps
module muldiv_seq #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start_i,
  input  logic [1:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cancel_i,
  output logic        busy_o,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_e;

  localparam logic [5:0] MUL_LAST = 6'(MUL_LAT);
  localparam logic [5:0] DIV_LAST = 6'd32;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] rq_q, rq_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        signed_op;
  logic [31:0] a_in_mag;
  logic [31:0] b_mag;
  logic [63:0] a_ext;
  logic [63:0] b_ext;
  logic [63:0] mul_prod;
  logic [32:0] trial;
  logic        fits;
  logic [31:0] quo;
  logic [31:0] rem;

  assign signed_op = ~op_q[0];
  assign a_in_mag  = (~op_i[0] & a_i[31]) ? (32'd0 - a_i) : a_i;
  assign b_mag     = (signed_op & b_q[31]) ? (32'd0 - b_q) : b_q;

  // Low 64 bits of a 64x64 product of the extended operands equal the exact
  // signed (or unsigned) 32x32 product.
  assign a_ext    = {{32{signed_op & a_q[31]}}, a_q};
  assign b_ext    = {{32{signed_op & b_q[31]}}, b_q};
  assign mul_prod = a_ext * b_ext;

  // Shifted remainder is 33 bits; its MSB set means the divisor always fits.
  assign trial = rq_q[63:31] - {1'b0, b_mag};
  assign fits  = rq_q[63] | ~trial[32];
  assign quo   = rq_q[31:0];
  assign rem   = rq_q[63:32];

  always_comb begin
    // NOTE: every variable gets a default first, so no branch can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rq_d    = rq_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = 6'd0;
        if (start_i && !cancel_i) begin
          op_d    = op_i;
          a_d     = a_i;
          b_d     = b_i;
          rq_d    = {32'd0, a_in_mag};
          state_d = op_i[1] ? S_DIV : S_MUL;
        end
      end

      S_MUL: begin
        if (cancel_i) begin
          state_d = S_IDLE;
          cnt_d   = 6'd0;
        end else begin
          if (cnt_q == 6'd0) rq_d = mul_prod;
          if (cnt_q == MUL_LAST) begin
            state_d = S_DONE;
            cnt_d   = 6'd0;
            hi_d    = rem;
            lo_d    = quo;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end

      S_DIV: begin
        if (cancel_i) begin
          state_d = S_IDLE;
          cnt_d   = 6'd0;
        end else if (cnt_q == DIV_LAST) begin
          state_d = S_DONE;
          cnt_d   = 6'd0;
          if (b_q == 32'd0) begin
            hi_d = a_q;
            lo_d = 32'hFFFF_FFFF;
          end else if (signed_op) begin
            lo_d = (a_q[31] ^ b_q[31]) ? (32'd0 - quo) : quo;
            hi_d = a_q[31] ? (32'd0 - rem) : rem;
          end else begin
            hi_d = rem;
            lo_d = quo;
          end
        end else begin
          cnt_d = cnt_q + 6'd1;
          rq_d  = fits ? {trial[31:0], rq_q[30:0], 1'b1} : {rq_q[62:0], 1'b0};
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = 6'd0;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: every register, datapath included, is reset; the block is small and
  // a defined post-reset HI/LO is observable.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      op_q    <= 2'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      rq_q    <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rq_q    <= rq_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign busy_o  = (state_q != S_IDLE);
  assign done_o  = (state_q == S_DONE) & ~cancel_i;
  assign stall_o = busy_o & ~done_o;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected HI/LO queued at start, popped on done_o.
// Two extra instances (MUL_LAT=1 and 8) cover the multiply latency range.
`timescale 1ns/1ps
module tb_muldiv_seq;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start_i;
  logic        start_aux;
  logic [1:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        cancel_i;

  logic        busy, stall, done;
  logic [31:0] hi, lo;
  logic        aux1_busy, aux1_stall, aux1_done;
  logic [31:0] aux1_hi, aux1_lo;
  logic        aux8_busy, aux8_stall, aux8_done;
  logic [31:0] aux8_hi, aux8_lo;

  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] sb_q[$];
  logic [63:0] last_res;

  muldiv_seq #(.MUL_LAT(MUL_LAT)) u_dut (
    .clk(clk), .resetn(resetn), .start_i(start_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .cancel_i(cancel_i), .busy_o(busy), .stall_o(stall), .done_o(done), .hi_o(hi), .lo_o(lo)
  );

  muldiv_seq #(.MUL_LAT(1)) u_dut_lat1 (
    .clk(clk), .resetn(resetn), .start_i(start_aux), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .cancel_i(cancel_i), .busy_o(aux1_busy), .stall_o(aux1_stall), .done_o(aux1_done),
    .hi_o(aux1_hi), .lo_o(aux1_lo)
  );

  muldiv_seq #(.MUL_LAT(8)) u_dut_lat8 (
    .clk(clk), .resetn(resetn), .start_i(start_aux), .op_i(op_i), .a_i(a_i), .b_i(b_i),
    .cancel_i(cancel_i), .busy_o(aux8_busy), .stall_o(aux8_stall), .done_o(aux8_done),
    .hi_o(aux8_hi), .lo_o(aux8_lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference result {hi, lo} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb;
    int     ia, ib;
    logic [63:0] r;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    ia = signed'(a);
    ib = signed'(b);
    r  = 64'd0;
    case (op)
      2'b00: r = 64'(sa * sb);
      2'b01: r = {32'd0, a} * {32'd0, b};
      default: begin
        if (b == 32'd0)                  r = {a, 32'hFFFF_FFFF};
        else if (op == 2'b11)            r = {a % b, a / b};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
        else                             r = {32'(ia % ib), 32'(ia / ib)};
      end
    endcase
    return r;
  endfunction

  always @(negedge clk) begin
    if (resetn && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        logic [63:0] e;
        e = sb_q.pop_front();
        check("hi", {32'd0, hi}, {32'd0, e[63:32]});
        check("lo", {32'd0, lo}, {32'd0, e[31:0]});
      end
    end
  end

  // Launch one op on the main instance, track latency/stall, end in the following IDLE cycle.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit poke);
    int k;
    int lat;
    lat = op[1] ? 33 : MUL_LAT + 1;
    sb_q.push_back(model(op, a, b));
    last_res = model(op, a, b);
    op_i = op; a_i = a; b_i = b; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    op_i = 2'($urandom); a_i = $urandom; b_i = $urandom;
    k = 0;
    @(negedge clk);
    while (!done && k < 60) begin
      check("stall_busy", {63'd0, stall}, 64'd1);
      if (poke && k == 5) begin
        start_i = 1'b1; op_i = ~op; a_i = $urandom; b_i = $urandom;
      end
      if (poke && k == 6) start_i = 1'b0;
      @(negedge clk);
      k++;
    end
    check("latency", 64'(k), 64'(lat));
    check("stall_at_done", {63'd0, stall}, 64'd0);
    check("busy_at_done", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    check("idle_after_done", {63'd0, busy}, 64'd0);
  endtask

  task automatic run_mul_all(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int k1, k2, k8;
    logic [63:0] r1, r8, e;
    e = model(op, a, b);
    sb_q.push_back(e);
    last_res = e;
    k1 = -1; k2 = -1; k8 = -1; r1 = '0; r8 = '0;
    op_i = op; a_i = a; b_i = b; start_i = 1'b1; start_aux = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; start_aux = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done && k2 < 0) k2 = k;
      if (aux1_done && k1 < 0) begin k1 = k; r1 = {aux1_hi, aux1_lo}; end
      if (aux8_done && k8 < 0) begin k8 = k; r8 = {aux8_hi, aux8_lo}; end
    end
    check("mul_lat2", 64'(k2), 64'(MUL_LAT + 1));
    check("mul_lat1", 64'(k1), 64'd2);
    check("mul_lat8", 64'(k8), 64'd9);
    check("mul_res_lat1", r1, e);
    check("mul_res_lat8", r8, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    resetn = 1'b0; start_i = 1'b0; start_aux = 1'b0; cancel_i = 1'b0;
    op_i = 2'd0; a_i = 32'd0; b_i = 32'd0; last_res = 64'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Basic divides, including sign handling and the overflow wrap.
    run_op(2'b11, 32'd100, 32'd7, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);

    // Multiply sign/unsigned on all latency variants.
    run_mul_all(2'b00, 32'hFFFF_FFFF, 32'd2);
    run_mul_all(2'b01, 32'hFFFF_FFFF, 32'd2);

    // Divide by zero, unsigned and signed.
    run_op(2'b11, 32'h1234_5678, 32'd0, 1'b0);
    run_op(2'b10, 32'hFFFF_FF00, 32'd0, 1'b0);

    // Cancel on iteration 10; then a start in the very next IDLE cycle.
    op_i = 2'b10; a_i = 32'd5000; b_i = 32'd3; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    k = 0;
    @(negedge clk);
    while (k < 10) begin @(negedge clk); k++; end
    cancel_i = 1'b1;
    @(posedge clk); #1;
    cancel_i = 1'b0;
    @(negedge clk);
    check("cancel_busy", {63'd0, busy}, 64'd0);
    check("cancel_hilo", {hi, lo}, last_res);
    run_op(2'b10, 32'hFFFF_FC00, 32'd9, 1'b0);

    // start_i while busy is ignored; operands stay latched.
    run_op(2'b11, 32'hDEAD_BEEF, 32'd1234, 1'b1);
    run_op(2'b10, 32'h7FFF_FFFF, 32'hFFFF_FFF0, 1'b1);

    // Reset asserted mid-divide.
    op_i = 2'b11; a_i = 32'd999; b_i = 32'd10; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (15) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_hilo", {hi, lo}, 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    last_res = 64'd0;
    @(negedge clk);
    check("postrst_busy", {63'd0, busy}, 64'd0);

    // start and cancel together in IDLE: nothing launches.
    op_i = 2'b11; a_i = 32'd77; b_i = 32'd5; start_i = 1'b1; cancel_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; cancel_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("startcancel_busy", {63'd0, busy}, 64'd0);
    end
    check("startcancel_hilo", {hi, lo}, last_res);

    // Random back-to-back mix.
    for (int i = 0; i < 8; i++) begin
      logic [1:0]  rop;
      logic [31:0] ra, rb;
      rop = 2'($urandom);
      ra  = $urandom;
      rb  = (i % 2 == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      run_op(rop, ra, rb, 1'b0);
    end

    repeat (2) @(negedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
